// File: rtl/hpdcache_refill_ctrl.sv
// Refill sequencer between the MSHR / memory read-response channel and the cache array.
// Acks the MSHR, writes each refill beat, and returns the missed word to the core.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | waiting for the first refill beat (needs the MSHR ack grant)
//  S_META  | MSHR metadata returned this cycle, latched at the end of it
//  S_WRITE | buffered beat presented to the array until accepted
//  S_BEAT  | waiting for the next refill beat
//  S_RSP   | core response held until accepted
module hpdcache_refill_ctrl #(
  parameter int MSHR_SET_W = 2,
  parameter int MSHR_WAY_W = 2,
  parameter int NLINE_W    = 26,
  parameter int REQ_ID_W   = 6,
  parameter int SRC_ID_W   = 3,
  parameter int WORD_W     = 64,
  parameter int WORD_IDX_W = 3,
  parameter int MEM_DATA_W = 128,
  localparam int LINE_W    = WORD_W << WORD_IDX_W,
  localparam int NBEATS    = LINE_W / MEM_DATA_W,
  localparam int BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         mem_rsp_valid_i,
  output logic                         mem_rsp_ready_o,
  input  logic [MSHR_WAY_W+MSHR_SET_W-1:0] mem_rsp_id_i,
  input  logic [MEM_DATA_W-1:0]        mem_rsp_data_i,
  input  logic                         mem_rsp_error_i,
  input  logic                         mem_rsp_last_i,
  input  logic                         mshr_ack_gnt_i,
  output logic                         mshr_ack_o,
  output logic [MSHR_SET_W-1:0]        mshr_ack_set_o,
  output logic [MSHR_WAY_W-1:0]        mshr_ack_way_o,
  input  logic [REQ_ID_W-1:0]          mshr_req_id_i,
  input  logic [SRC_ID_W-1:0]          mshr_src_id_i,
  input  logic [NLINE_W-1:0]           mshr_nline_i,
  input  logic [WORD_IDX_W-1:0]        mshr_word_i,
  input  logic                         mshr_need_rsp_i,
  input  logic                         mshr_is_pref_i,
  output logic                         refill_write_o,
  input  logic                         refill_ready_i,
  output logic [NLINE_W-1:0]           refill_nline_o,
  output logic [BEAT_W-1:0]            refill_beat_o,
  output logic [MEM_DATA_W-1:0]        refill_data_o,
  output logic                         core_rsp_valid_o,
  input  logic                         core_rsp_ready_i,
  output logic [REQ_ID_W-1:0]          core_rsp_req_id_o,
  output logic [SRC_ID_W-1:0]          core_rsp_src_id_o,
  output logic [WORD_W-1:0]            core_rsp_data_o,
  output logic                         core_rsp_error_o,
  output logic                         busy_o
);

  localparam int WPB    = MEM_DATA_W / WORD_W;
  localparam int WSEL_W = $clog2(WPB);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_META  = 3'd1,
    S_WRITE = 3'd2,
    S_BEAT  = 3'd3,
    S_RSP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [MEM_DATA_W-1:0]   data_q, data_d;
  logic                    err_q, err_d;
  logic                    last_q, last_d;
  logic [NLINE_W-1:0]      nline_q, nline_d;
  logic [REQ_ID_W-1:0]     req_id_q, req_id_d;
  logic [SRC_ID_W-1:0]     src_id_q, src_id_d;
  logic [WORD_IDX_W-1:0]   word_q, word_d;
  logic                    need_rsp_q, need_rsp_d;
  logic                    is_pref_q, is_pref_d;
  logic [WORD_W-1:0]       rsp_word_q, rsp_word_d;

  logic [WORD_IDX_W-1:0]   word_beat;
  logic [WORD_IDX_W-1:0]   word_off;
  logic                    word_hit;
  logic [WORD_W-1:0]       word_sel;
  logic [BEAT_W-1:0]       beat_inc;

  // Requested word lives in beat word/WPB at slot word%WPB of that beat.
  always_comb begin
    word_beat = word_q >> WSEL_W;
    word_off  = word_q & WORD_IDX_W'(WPB - 1);
    word_hit  = (word_beat == WORD_IDX_W'(beat_q));
    word_sel  = data_q[WORD_W-1:0];
    for (int i = 0; i < WPB; i++) begin
      if (word_off == WORD_IDX_W'(i)) word_sel = data_q[i*WORD_W +: WORD_W];
    end
    beat_inc = (beat_q == BEAT_W'(NBEATS - 1)) ? '0 : beat_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    data_d     = data_q;
    err_d      = err_q;
    last_d     = last_q;
    nline_d    = nline_q;
    req_id_d   = req_id_q;
    src_id_d   = src_id_q;
    word_d     = word_q;
    need_rsp_d = need_rsp_q;
    is_pref_d  = is_pref_q;
    rsp_word_d = rsp_word_q;

    mem_rsp_ready_o  = 1'b0;
    mshr_ack_o       = 1'b0;
    mshr_ack_set_o   = '0;
    mshr_ack_way_o   = '0;
    refill_write_o   = 1'b0;
    core_rsp_valid_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        mem_rsp_ready_o = mshr_ack_gnt_i;
        if (mem_rsp_valid_i && mshr_ack_gnt_i) begin
          mshr_ack_o     = 1'b1;
          mshr_ack_set_o = mem_rsp_id_i[MSHR_SET_W-1:0];
          mshr_ack_way_o = mem_rsp_id_i[MSHR_WAY_W+MSHR_SET_W-1:MSHR_SET_W];
          data_d         = mem_rsp_data_i;
          err_d          = mem_rsp_error_i;
          last_d         = mem_rsp_last_i;
          beat_d         = '0;
          rsp_word_d     = '0;
          state_d        = S_META;
        end
      end
      S_META: begin
        nline_d    = mshr_nline_i;
        req_id_d   = mshr_req_id_i;
        src_id_d   = mshr_src_id_i;
        word_d     = mshr_word_i;
        need_rsp_d = mshr_need_rsp_i;
        is_pref_d  = mshr_is_pref_i;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        refill_write_o = 1'b1;
        if (refill_ready_i) begin
          if (word_hit) rsp_word_d = word_sel;
          if (!last_q) state_d = S_BEAT;
          else if (need_rsp_q && !is_pref_q) state_d = S_RSP;
          else state_d = S_IDLE;
        end
      end
      S_BEAT: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i) begin
          beat_d  = beat_inc;
          err_d   = err_q | mem_rsp_error_i;
          data_d  = mem_rsp_data_i;
          last_d  = mem_rsp_last_i;
          state_d = S_WRITE;
        end
      end
      S_RSP: begin
        core_rsp_valid_o = 1'b1;
        if (core_rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      nline_q    <= '0;
      req_id_q   <= '0;
      src_id_q   <= '0;
      word_q     <= '0;
      need_rsp_q <= 1'b0;
      is_pref_q  <= 1'b0;
      rsp_word_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      data_q     <= data_d;
      err_q      <= err_d;
      last_q     <= last_d;
      nline_q    <= nline_d;
      req_id_q   <= req_id_d;
      src_id_q   <= src_id_d;
      word_q     <= word_d;
      need_rsp_q <= need_rsp_d;
      is_pref_q  <= is_pref_d;
      rsp_word_q <= rsp_word_d;
    end
  end

  assign refill_nline_o    = nline_q;
  assign refill_beat_o     = beat_q;
  assign refill_data_o     = data_q;
  assign core_rsp_req_id_o = req_id_q;
  assign core_rsp_src_id_o = src_id_q;
  assign core_rsp_data_o   = rsp_word_q;
  assign core_rsp_error_o  = err_q;
  assign busy_o            = (state_q != S_IDLE);

endmodule

// File: tb/tb_hpdcache_refill_ctrl.sv
// Directed + randomized bench for hpdcache_refill_ctrl; expected values come from a
// line-level model (beats concatenated into a line, word picked by index).
module tb_hpdcache_refill_ctrl;

  logic         clk, rst_n;
  logic         mem_valid, mem_ready, mem_err, mem_last;
  logic [3:0]   mem_id;
  logic [127:0] mem_data;
  logic         gnt, ack;
  logic [1:0]   ack_set, ack_way;
  logic [5:0]   m_req_id;
  logic [2:0]   m_src_id;
  logic [25:0]  m_nline;
  logic [2:0]   m_word;
  logic         m_need, m_pref;
  logic         wr, wr_ready;
  logic [25:0]  wr_nline;
  logic [1:0]   wr_beat;
  logic [127:0] wr_data;
  logic         c_valid, c_ready, c_err, busy;
  logic [5:0]   c_req_id;
  logic [2:0]   c_src_id;
  logic [63:0]  c_data;

  int n_asrt = 0;
  int n_fail = 0;
  logic [127:0] beats[4];
  logic         errs[4];

  hpdcache_refill_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_rsp_valid_i(mem_valid), .mem_rsp_ready_o(mem_ready), .mem_rsp_id_i(mem_id),
    .mem_rsp_data_i(mem_data), .mem_rsp_error_i(mem_err), .mem_rsp_last_i(mem_last),
    .mshr_ack_gnt_i(gnt), .mshr_ack_o(ack), .mshr_ack_set_o(ack_set), .mshr_ack_way_o(ack_way),
    .mshr_req_id_i(m_req_id), .mshr_src_id_i(m_src_id), .mshr_nline_i(m_nline),
    .mshr_word_i(m_word), .mshr_need_rsp_i(m_need), .mshr_is_pref_i(m_pref),
    .refill_write_o(wr), .refill_ready_i(wr_ready), .refill_nline_o(wr_nline),
    .refill_beat_o(wr_beat), .refill_data_o(wr_data),
    .core_rsp_valid_o(c_valid), .core_rsp_ready_i(c_ready), .core_rsp_req_id_o(c_req_id),
    .core_rsp_src_id_o(c_src_id), .core_rsp_data_o(c_data), .core_rsp_error_o(c_err),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_beats(input int err_pct);
    for (int i = 0; i < 4; i++) begin
      beats[i] = {$urandom, $urandom, $urandom, $urandom};
      errs[i]  = ($urandom_range(0, 99) < err_pct);
    end
  endtask

  task automatic run_refill(input logic [1:0] way, input logic [1:0] set, input int nb,
                            input logic [5:0] rid, input logic [2:0] sid, input logic [25:0] nl,
                            input logic [2:0] wd, input logic need, input logic pref,
                            input int gnt_dly, input int wr_stall, input int rsp_stall);
    logic [511:0] line;
    logic         exp_err;
    logic         exp_rsp;
    line    = '0;
    exp_err = 1'b0;
    for (int b = 0; b < nb; b++) begin
      line[b*128 +: 128] = beats[b];
      exp_err |= errs[b];
    end
    exp_rsp = need && !pref;

    @(negedge clk);
    mem_valid = 1'b1; mem_id = {way, set}; mem_data = beats[0];
    mem_err = errs[0]; mem_last = (nb == 1); gnt = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      #1;
      chk("ready_nogrant", mem_ready, 0);
      chk("ack_nogrant", ack, 0);
      @(negedge clk);
    end
    gnt = 1'b1;
    #1;
    chk("ready_grant", mem_ready, 1);
    chk("ack", ack, 1);
    chk("ack_set", ack_set, set);
    chk("ack_way", ack_way, way);
    @(negedge clk);
    mem_valid = 1'b0; gnt = 1'b0; mem_data = {$urandom, $urandom, $urandom, $urandom};
    m_req_id = rid; m_src_id = sid; m_nline = nl; m_word = wd; m_need = need; m_pref = pref;
    #1;
    chk("meta_ready", mem_ready, 0);
    chk("meta_ack", ack, 0);
    chk("meta_busy", busy, 1);
    @(negedge clk);
    {m_req_id, m_src_id, m_nline, m_word, m_need, m_pref} = {$urandom, $urandom};

    for (int b = 0; b < nb; b++) begin
      for (int s = 0; s <= wr_stall; s++) begin
        wr_ready = (s == wr_stall);
        #1;
        chk("wr_valid", wr, 1);
        chk("wr_nline", wr_nline, nl);
        chk("wr_beat", wr_beat, b[1:0]);
        chk("wr_data", wr_data, beats[b]);
        chk("wr_mem_ready", mem_ready, 0);
        chk("wr_no_rsp", c_valid, 0);
        @(negedge clk);
      end
      wr_ready = 1'b0;
      if (b < nb - 1) begin
        mem_valid = 1'b1; mem_data = beats[b+1]; mem_err = errs[b+1]; mem_last = (b + 1 == nb - 1);
        #1;
        chk("beat_ready", mem_ready, 1);
        chk("beat_no_wr", wr, 0);
        @(negedge clk);
        mem_valid = 1'b0; mem_err = 1'b0; mem_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end

    if (exp_rsp) begin
      for (int s = 0; s <= rsp_stall; s++) begin
        c_ready = (s == rsp_stall);
        #1;
        chk("rsp_valid", c_valid, 1);
        chk("rsp_data", c_data, line[wd*64 +: 64]);
        chk("rsp_req_id", c_req_id, rid);
        chk("rsp_src_id", c_src_id, sid);
        chk("rsp_error", c_err, exp_err);
        @(negedge clk);
      end
      c_ready = 1'b0;
    end
    #1;
    chk("end_idle", busy, 0);
    chk("end_no_rsp", c_valid, 0);
    chk("end_no_wr", wr, 0);
  endtask

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_id = '0; mem_data = '0; mem_err = 1'b0; mem_last = 1'b0;
    gnt = 1'b0; m_req_id = '0; m_src_id = '0; m_nline = '0; m_word = '0; m_need = 1'b0;
    m_pref = 1'b0; wr_ready = 1'b0; c_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr", wr, 0);
    chk("rst_rsp", c_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_beat", wr_beat, 0);
    chk("rst_data", wr_data, 0);
    rst_n = 1'b1;

    // 4-beat refill, id={way1,set2}, word 5 -> beat2 upper half
    rand_beats(0);
    run_refill(2'd1, 2'd2, 4, 6'h2a, 3'd5, 26'h12345f, 3'd5, 1'b1, 1'b0, 0, 0, 0);
    chk("word5_is_beat2_hi", c_data, beats[2][127:64]);

    // prefetch: writes happen, no core response
    rand_beats(0);
    run_refill(2'd3, 2'd0, 4, 6'h11, 3'd1, 26'h0abcde, 3'd2, 1'b1, 1'b1, 0, 0, 0);

    // grant withheld 5 cycles
    rand_beats(0);
    run_refill(2'd2, 2'd1, 4, 6'h05, 3'd2, 26'h3ffffff, 3'd0, 1'b1, 1'b0, 5, 0, 0);

    // error on beat 1 only
    rand_beats(0);
    errs[1] = 1'b1;
    run_refill(2'd0, 2'd3, 4, 6'h3f, 3'd7, 26'h0000001, 3'd7, 1'b1, 1'b0, 0, 0, 0);

    // backpressure on array and core
    rand_beats(0);
    run_refill(2'd1, 2'd1, 4, 6'h20, 3'd3, 26'h1555555, 3'd3, 1'b1, 1'b0, 1, 3, 4);

    // early last: 2-beat refill
    rand_beats(0);
    run_refill(2'd2, 2'd2, 2, 6'h07, 3'd4, 26'h2222222, 3'd3, 1'b1, 1'b0, 0, 1, 1);

    // reset pulse while beat 1 is being written
    rand_beats(0);
    @(negedge clk);
    mem_valid = 1'b1; mem_id = 4'b0110; mem_data = beats[0]; mem_err = 1'b0; mem_last = 1'b0; gnt = 1'b1;
    #1;
    chk("rstmid_ack", ack, 1);
    @(negedge clk);
    mem_valid = 1'b0; gnt = 1'b0; m_nline = 26'h0cafe00; m_word = 3'd1; m_need = 1'b1; m_pref = 1'b0;
    @(negedge clk);
    wr_ready = 1'b1;
    #1;
    chk("rstmid_wr0", wr, 1);
    @(negedge clk);
    wr_ready = 1'b0; mem_valid = 1'b1; mem_data = beats[1];
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    chk("rstmid_wr1_beat", wr_beat, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_wr", wr, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ack0", ack, 0);
    chk("rstmid_rsp", c_valid, 0);
    chk("rstmid_beat", wr_beat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_beats(0);
    run_refill(2'd1, 2'd2, 4, 6'h19, 3'd6, 26'h0cafe01, 3'd6, 1'b1, 1'b0, 0, 0, 0);

    // randomized refills
    for (int n = 0; n < 24; n++) begin
      int nb;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 4;
      rand_beats(25);
      run_refill(2'($urandom), 2'($urandom), nb, 6'($urandom), 3'($urandom), 26'($urandom),
                 3'($urandom_range(0, 2 * nb - 1)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
